// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizing for the run controller.
package run_ctrl_pkg;

  // Phases of a single program run.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  // Default sizing: PC width, reset hold length and run-counter width.
  localparam int RC_D          = 12;
  localparam int RC_RST_CYCLES = 2;
  localparam int RC_CNT_W      = 16;

  // All-ones value at which the default-width run counter saturates.
  localparam logic [RC_CNT_W-1:0] RC_CNT_SAT = '1;

endpackage

// File: rtl/run_ctrl_edge_det.sv
// Registered rising-edge detector for the run request line.
module run_ctrl_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Remember last cycle's level so a new request can be told from a held one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset, lets it run, stops it on halt or
// on the cycle limit, and arbitrates the data memory with a host loader.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int D          = RC_D,
  parameter int RST_CYCLES = RC_RST_CYCLES,
  parameter int CNT_W      = RC_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             core_halt,
  input  logic [D-1:0]     prog_ctr,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             core_reset,
  output logic             core_en,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [D-1:0]     end_pc,
  input  logic             host_req,
  output logic             host_gnt
);

  localparam int               HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

  run_state_t        state;
  run_state_t        state_next;
  logic              start;
  logic              pending;
  logic              idle_like;
  logic              launch;
  logic              limit_hit;
  logic [HOLD_W-1:0] hold_cnt;

  run_ctrl_edge_det u_req_edge (
    .clk   (clk),
    .reset (reset),
    .d     (req),
    .rise  (start)
  );

  // A run may only launch from a quiet state once the host has fully let go
  // of the memory, either on a fresh edge or on one deferred earlier.
  assign idle_like = (state == IDLE) || (state == DONE);
  assign launch    = idle_like && (start || pending) && !host_gnt && !host_req;

  // Compare in one extra bit so count+1 cannot wrap onto a small limit.
  assign limit_hit = (max_cycles != '0) &&
                     ((CNT_W+1)'(cycle_count) + (CNT_W+1)'(1) == (CNT_W+1)'(max_cycles));

  // Next-state and core control decode; the core is kept in reset unless running or stopped.
  always_comb begin
    state_next = state;
    core_reset = 1'b1;
    core_en    = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (launch) state_next = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) state_next = RUN;
      end
      RUN: begin
        core_reset = 1'b0;
        core_en    = 1'b1;
        if (core_halt || limit_hit) state_next = DONE;
      end
      DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (launch) state_next = HOLD;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset aborts any run in progress without signalling done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Counts down the cycles the core stays in reset before it may run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                hold_cnt <= '0;
    else if (launch)                          hold_cnt <= HOLD_INIT;
    else if (state == HOLD && hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
  end

  // Run statistics: saturating cycle count, and end PC / cause captured on exit; halt beats the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
      timeout     <= 1'b0;
      end_pc      <= '0;
    end else if (launch) begin
      cycle_count <= '0;
      timeout     <= 1'b0;
    end else if (state == RUN) begin
      if (cycle_count != CNT_SAT) cycle_count <= cycle_count + CNT_W'(1);
      if (core_halt) begin
        end_pc  <= prog_ctr;
        timeout <= 1'b0;
      end else if (limit_hit) begin
        end_pc  <= prog_ctr;
        timeout <= 1'b1;
      end
    end
  end

  // Remembers a start that arrived while the host held or wanted the memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   pending <= 1'b0;
    else if (launch)             pending <= 1'b0;
    else if (idle_like && start) pending <= 1'b1;
  end

  // Host grant follows host_req a cycle later, but only while the core is parked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) host_gnt <= 1'b0;
    else       host_gnt <= host_req && idle_like && !launch;
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: drives runs, predicts each run's outcome from
// the halt cycle and limit, and checks the result whenever done rises.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int D   = 12;
  localparam int RST = 2;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          core_halt;
  logic [D-1:0]  prog_ctr;
  logic [CW-1:0] max_cycles;
  logic          host_req;
  logic          core_reset;
  logic          core_en;
  logic          done;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [D-1:0]  end_pc;
  logic          host_gnt;

  typedef struct {
    int           count;
    bit           tmo;
    logic [D-1:0] pc;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  run_ctrl #(.D(D), .RST_CYCLES(RST), .CNT_W(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .core_halt   (core_halt),
    .prog_ctr    (prog_ctr),
    .max_cycles  (max_cycles),
    .core_reset  (core_reset),
    .core_en     (core_en),
    .done        (done),
    .timeout     (timeout),
    .cycle_count (cycle_count),
    .end_pc      (end_pc),
    .host_req    (host_req),
    .host_gnt    (host_gnt)
  );

  // Free-running clock and a posedge counter used to time expected events.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: on each rising done, pop the prediction and compare the run report.
  initial begin : monitor
    exp_t e;
    bit   prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !prev) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got done=1, expected no run end (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check_output("cycle_count", cycle_count, e.count);
          check_output("timeout", timeout, e.tmo);
          check_output("end_pc", end_pc, e.pc);
          check_output("done_cycle", cyc, e.done_cyc);
        end
      end
      prev = (done === 1'b1);
    end
  end

  // One run: limit m, halt on RUN cycle h (0 = never), optional host deferral / host contention.
  task automatic apply_stimulus(input int m, input int h, input logic [D-1:0] base,
                                input bit deferred, input bit host_in_run);
    int   k;
    bit   tmo;
    exp_t e;
    if (h == 0)                 begin k = m; tmo = 1'b1; end
    else if (m == 0 || h <= m)  begin k = h; tmo = 1'b0; end
    else                        begin k = m; tmo = 1'b1; end
    @(negedge clk);
    max_cycles = CW'(m);
    core_halt  = 1'b0;
    host_req   = 1'b0;
    req        = 1'b0;
    if (deferred) begin
      host_req = 1'b1;
      @(negedge clk);
      check_output("gnt_rise", host_gnt, 1);
      req = 1'b1;
      @(negedge clk);
      check_output("defer_en", core_en, 0);
      check_output("gnt_hold", host_gnt, 1);
      req = 1'b0;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      check_output("defer_en2", core_en, 0);
      host_req = 1'b0;
      @(negedge clk);
      check_output("gnt_fall", host_gnt, 0);
      check_output("defer_en3", core_en, 0);
    end else begin
      @(negedge clk);
      req = 1'b1;
    end
    e.count    = k;
    e.tmo      = tmo;
    e.pc       = base + D'(k);
    e.done_cyc = cyc + 1 + RST + k;
    sb.push_back(e);
    for (int i = 0; i < RST + k; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (i < RST) begin
        check_output("hold_reset", core_reset, 1);
        check_output("hold_en", core_en, 0);
        check_output("hold_done", done, 0);
        check_output("hold_gnt", host_gnt, 0);
      end else begin
        int j;
        j = i - RST + 1;
        check_output("run_en", core_en, 1);
        check_output("run_reset", core_reset, 0);
        check_output("run_gnt", host_gnt, 0);
        prog_ctr  = base + D'(j);
        core_halt = (j == h);
        if (host_in_run) host_req = 1'b1;
      end
    end
    @(negedge clk);
    core_halt = 1'b0;
    check_output("done_en", core_en, 0);
    check_output("done_reset", core_reset, 0);
    check_output("done_gnt", host_gnt, 0);
    if (host_in_run) begin
      @(negedge clk);
      check_output("gnt_after_done", host_gnt, 1);
      host_req = 1'b0;
      @(negedge clk);
      check_output("gnt_release", host_gnt, 0);
    end
  endtask

  // Start an unlimited run and hit reset in its fourth RUN cycle.
  task automatic abort_run();
    @(negedge clk);
    max_cycles = '0;
    core_halt  = 1'b0;
    host_req   = 1'b0;
    req        = 1'b0;
    @(negedge clk);
    req = 1'b1;
    for (int i = 0; i < RST + 4; i++) begin
      @(negedge clk);
      req = 1'b0;
    end
    check_output("pre_abort_en", core_en, 1);
    reset = 1'b1;
    #1;
    check_output("abort_reset", core_reset, 1);
    check_output("abort_en", core_en, 0);
    check_output("abort_done", done, 0);
    check_output("abort_count", cycle_count, 0);
    check_output("abort_timeout", timeout, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Safety net so a stuck design cannot hang the run.
  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset values, directed scenarios, then random runs.
  initial begin : driver
    int m;
    int h;
    reset      = 1'b1;
    req        = 1'b0;
    core_halt  = 1'b0;
    prog_ctr   = '0;
    max_cycles = '0;
    host_req   = 1'b1;
    repeat (2) @(negedge clk);
    check_output("rst_core_reset", core_reset, 1);
    check_output("rst_core_en", core_en, 0);
    check_output("rst_done", done, 0);
    check_output("rst_timeout", timeout, 0);
    check_output("rst_count", cycle_count, 0);
    check_output("rst_end_pc", end_pc, 0);
    check_output("rst_gnt", host_gnt, 0);
    host_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    apply_stimulus(0, 10, 12'h050, 1'b0, 1'b0);
    apply_stimulus(5, 0, 12'h3C0, 1'b0, 1'b0);
    apply_stimulus(3, 3, 12'h111, 1'b0, 1'b0);
    apply_stimulus(0, 4, 12'h700, 1'b1, 1'b0);
    apply_stimulus(0, 6, 12'h222, 1'b0, 1'b1);
    abort_run();
    apply_stimulus(0, 7, 12'hABC, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      m = $urandom_range(0, 12);
      h = $urandom_range((m == 0) ? 1 : 0, 15);
      apply_stimulus(m, h, D'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_done: got no done, expected done at cycle %0d", e.done_cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
- Sequences one program run of the 9-bit-ISA core.
- On a start request it holds the core in reset, releases it, and counts run cycles. It ends the run on the core's halt or on a cycle-limit timeout, then reports done.
- It also shares the core's data memory with an external host loader port. The host is granted only while the core is not running.
- Sits between the bench/host and the top-level core: drives core reset/enable and the data-memory source select.

Parameters:
- D, 12, program-counter width (matches the core PC).
- RST_CYCLES, 2, cycles core_reset is held high at run start (>=1).
- CNT_W, 16, width of the run-cycle counter and limit.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  run request; a run starts on its rising edge.
- core_halt  input  1  core decoded its halt instruction this cycle.
- prog_ctr  input  D  core PC; captured at run end.
- max_cycles  input  CNT_W  run-cycle limit; 0 = no limit.
- core_reset  output  1  reset to core PC/register mapper.
- core_en  output  1  core advance enable.
- done  output  1  run finished (level).
- timeout  output  1  last run ended by limit, not halt.
- cycle_count  output  CNT_W  RUN cycles in current/last run.
- end_pc  output  D  PC captured when run ended.
- host_req  input  1  host requests data-memory access.
- host_gnt  output  1  host owns data memory; also the memory source select (1 = host).

Behaviour:
- Reset-asserted values:
  - state IDLE, core_reset=1, core_en=0, done=0, timeout=0.
  - cycle_count=0, end_pc=0, host_gnt=0, req edge register=0.
- Reset is asynchronous. Asserting it mid-run aborts immediately with no done pulse.
- req_q registers req. start = req & ~req_q.
- States:
  - IDLE:
    - core_reset=1, core_en=0.
    - On start with host_gnt=0 and host_req=0: clear cycle_count, timeout and done; load hold counter with RST_CYCLES-1; go to HOLD.
  - HOLD:
    - core_reset=1, core_en=0.
    - Decrement the hold counter; at 0 go to RUN.
    - Exactly RST_CYCLES cycles are spent in HOLD.
  - RUN:
    - core_reset=0, core_en=1.
    - cycle_count increments every cycle and saturates at all-ones.
    - If core_halt=1: capture end_pc=prog_ctr and go to DONE with timeout=0.
    - Else if max_cycles!=0 and cycle_count+1==max_cycles: capture end_pc and go to DONE with timeout=1.
    - If both conditions hold in the same cycle, halt wins (timeout=0).
  - DONE:
    - core_en=0, core_reset=0 (core state visible for inspection), done=1.
    - On start: same as the IDLE start path, and done drops in the cycle HOLD is entered.
- Start deferral:
  - A start edge while host_gnt=1 or host_req=1 is latched as pending.
  - The run begins in the first cycle where host_req=0 and host_gnt=0.
  - Further edges while pending are absorbed.
  - Start edges in HOLD or RUN are ignored.
- Host arbitration:
  - host_gnt is registered. It rises the cycle after host_req=1 while state is IDLE or DONE with no start launching that cycle.
  - It falls the cycle after host_req=0.
  - In HOLD and RUN, host_gnt stays 0 regardless of host_req.
  - host_gnt never overlaps core_en=1.
- Latency:
  - Start edge to first core_en=1 is RST_CYCLES+1 cycles.
  - Halt cycle to done=1 is 1 cycle.

Decomposition:
- Shared package run_ctrl_pkg:
  - state enum run_state_t {IDLE, HOLD, RUN, DONE}.
  - localparam for the saturated count value.
- Optional sub-module edge_det (1-bit rising-edge detector) is natural.
- Counters and arbitration stay inline.

Test Plan:
- Basic run: RST_CYCLES=2, max_cycles=0. Pulse req; assert core_halt at the 10th RUN cycle with prog_ctr=12'h05A. Required: core_reset high 2 cycles after start, cycle_count=10, end_pc=12'h05A, done=1 next cycle, timeout=0.
- Timeout: max_cycles=5, no halt. Required: DONE after exactly 5 RUN cycles, timeout=1, cycle_count=5.
- Halt and limit coincide: max_cycles=3, core_halt on RUN cycle 3. Required: timeout=0, done=1.
- Host deferral: host_req=1, host_gnt=1, then req rising edge. Required: state stays IDLE. Drop host_req at T. Required: host_gnt=0 at T+1, HOLD entered at T+1 or T+2, never with host_gnt=1.
- Host blocked: host_req=1 during RUN. Required: host_gnt stays 0 until DONE, then rises 1 cycle later.
- Reset mid-run: assert reset in RUN cycle 4. Required: immediate core_reset=1, core_en=0, done=0, cycle_count=0. After release, a new req runs normally.
